// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.

`ifndef IFU_FETCH_DEFINES
`define IFU_FETCH_DEFINES
`define INST_NOP  32'h0000_0013
`define ZERO_WORD 32'h0000_0000
`define RESET_PC  32'h0000_0000
`define INST_W    32
`define ADDR_W    32
`endif

package ifu_fetch_pkg;

    localparam int unsigned INST_W = `INST_W;
    localparam int unsigned ADDR_W = `ADDR_W;

    // One instruction buffer entry: fetched word plus the address it came from.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
    } ibuf_entry_t;

    localparam int unsigned IBUF_W = INST_W + ADDR_W;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used for the fetch address queue and instruction buffer.
// Flush has priority over push and pop; the read port shows the head combinationally.

module fetch_fifo
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [$clog2(DEPTH):0] DEPTH_CNT = ($clog2(DEPTH) + 1)'(DEPTH);

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [AW-1:0]          wptr_q;
    logic [AW-1:0]          rptr_q;
    logic [$clog2(DEPTH):0] count_q;
    logic                   do_push;
    logic                   do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem[rptr_q];

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            if (do_push && !do_pop) begin
                count_q <= count_q + ($clog2(DEPTH) + 1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - ($clog2(DEPTH) + 1)'(1);
            end
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches over a
// req/gnt/rvalid handshake and presents buffered instructions to IF/ID.
// Responses that belong to fetches issued before a redirect are counted in drop_q
// and discarded as they arrive.

module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = `RESET_PC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_CNT = (CW + 1)'(BUF_DEPTH);

    logic [31:0]       pc_q;
    logic [CW-1:0]     out_q;     // fetches granted but not yet answered
    logic [CW-1:0]     drop_q;    // of those, how many are stale
    logic [CW:0]       credit_used;
    logic              grant;
    logic              rsp;
    logic              keep;
    logic              pop;
    logic              head_valid;

    logic [31:0]       aq_addr;
    logic              aq_full;
    logic              aq_empty;
    logic [CW-1:0]     aq_count;

    logic [IBUF_W-1:0] ib_rdata;
    ibuf_entry_t       ib_head;
    ibuf_entry_t       ib_wdata;
    logic              ib_full;
    logic              ib_empty;
    logic [CW-1:0]     ib_count;

    logic              unused_bits;

    assign head_valid = !ib_empty && !jump_en_i;
    assign pop        = head_valid && !hold_i;

    // Every granted fetch reserves a buffer slot; count what a new fetch would have to share.
    assign credit_used = {1'b0, out_q} + {1'b0, ib_count} - {{CW{1'b0}}, pop};

    assign imem_req_o  = rst_n && !jump_en_i && (credit_used < DEPTH_CNT);
    assign imem_addr_o = {pc_q[31:2], 2'b00};

    assign grant = imem_req_o && imem_gnt_i;
    assign rsp   = imem_rvalid_i && (out_q != '0);
    assign keep  = rsp && (drop_q == '0);

    assign ib_wdata = '{inst: imem_rdata_i, addr: aq_addr};
    assign ib_head  = ib_rdata;

    // PC, outstanding-fetch and stale-response counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            out_q  <= '0;
            drop_q <= '0;
        end else begin
            if (jump_en_i) begin
                pc_q <= {jump_addr_i[31:2], 2'b00};
            end else if (grant) begin
                pc_q <= pc_q + 32'd4;
            end

            if (grant && !rsp) begin
                out_q <= out_q + CW'(1);
            end else if (!grant && rsp) begin
                out_q <= out_q - CW'(1);
            end

            // Everything still in flight after this cycle is stale; this subsumes any
            // earlier drop count, so back-to-back redirects stay consistent.
            if (jump_en_i) begin
                drop_q <= out_q - CW'(rsp);
            end else if (rsp && (drop_q != '0)) begin
                drop_q <= drop_q - CW'(1);
            end
        end
    end

    // Addresses of live (non-stale) fetches, in issue order.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (BUF_DEPTH)
    ) u_addr_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (grant),
        .wdata_i (imem_addr_o),
        .pop_i   (keep),
        .flush_i (jump_en_i),
        .rdata_o (aq_addr),
        .full_o  (aq_full),
        .empty_o (aq_empty),
        .count_o (aq_count)
    );

    // Returned instructions paired with their addresses.
    fetch_fifo #(
        .WIDTH (IBUF_W),
        .DEPTH (BUF_DEPTH)
    ) u_inst_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (keep && !jump_en_i),
        .wdata_i (ib_wdata),
        .pop_i   (pop),
        .flush_i (jump_en_i),
        .rdata_o (ib_rdata),
        .full_o  (ib_full),
        .empty_o (ib_empty),
        .count_o (ib_count)
    );

    // Present the buffer head, or a NOP bubble when empty or redirecting.
    always_comb begin
        inst_valid_o = head_valid;
        inst_o       = `INST_NOP;
        inst_addr_o  = `ZERO_WORD;
        if (head_valid) begin
            inst_o      = ib_head.inst;
            inst_addr_o = ib_head.addr;
        end
    end

    assign unused_bits = ^{jump_addr_i[1:0], pc_q[1:0], aq_full, aq_empty, aq_count, ib_full};

endmodule
